// File: rtl/router_oport_arbiter.sv
// Output-port arbiter for the 16-port serial router: snoops every input's serial header,
// round-robins among inputs addressed to PORT_ID, holds the grant for a whole packet.
// Define ROUTER_ARB_TIMEOUT_EN to build the grant watchdog (TIMEOUT cycles without payload).

module router_oport_in_fsm #(
  parameter int ADDR_W  = 4,
  parameter int PORT_ID = 0
) (
  input  logic SystemClk,
  input  logic reset_n,
  input  logic frame_n_i,
  input  logic valid_n_i,
  input  logic din_i,
  input  logic gnt_i,
  input  logic kill_i,
  output logic req_o,
  output logic err_o
);
  localparam int CW = $clog2(ADDR_W + 1);

  typedef enum logic [2:0] {IDLE, ADDR, REQ, DATA, FOREIGN} st_e;

  st_e               st_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     cnt_q;
  logic              fr_prev_q;
  logic [ADDR_W-1:0] addr_full;
  logic              last_bit;

  assign addr_full = addr_q | (ADDR_W'(din_i) << cnt_q);
  assign last_bit  = frame_n_i & ~valid_n_i;
  assign req_o     = (st_q == REQ);
  assign err_o     = ((st_q == ADDR) & frame_n_i) | ((st_q == REQ) & ~gnt_i & ~valid_n_i);

  // A packet only starts on a frame_n falling edge, so a frame already low
  // after reset or after a watchdog kill is ignored until it goes high.
  always_ff @(posedge SystemClk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      fr_prev_q <= 1'b0;
    end else begin
      fr_prev_q <= frame_n_i;
      if (kill_i) st_q <= IDLE;
      else begin
        case (st_q)
          IDLE: if (!frame_n_i && fr_prev_q) begin
            addr_q <= ADDR_W'(din_i);
            cnt_q  <= CW'(1);
            if (ADDR_W == 1) st_q <= (ADDR_W'(din_i) == ADDR_W'(PORT_ID)) ? REQ : FOREIGN;
            else             st_q <= ADDR;
          end
          ADDR: if (frame_n_i) st_q <= IDLE;
          else begin
            addr_q <= addr_full;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(ADDR_W - 1))
              st_q <= (addr_full == ADDR_W'(PORT_ID)) ? REQ : FOREIGN;
          end
          REQ:     if (gnt_i) st_q <= last_bit ? IDLE : DATA;
          DATA:    if (last_bit) st_q <= IDLE;
          FOREIGN: if (last_bit) st_q <= IDLE;
          default: st_q <= IDLE;
        endcase
      end
    end
  end
endmodule

module router_oport_arbiter #(
  parameter int NUM_IN  = 16,
  parameter int ADDR_W  = 4,
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 64
) (
  input  logic              SystemClk,
  input  logic              reset_n,
  input  logic [NUM_IN-1:0] frame_n,
  input  logic [NUM_IN-1:0] valid_n,
  input  logic [NUM_IN-1:0] din,
  output logic [NUM_IN-1:0] busy_n,
  output logic [NUM_IN-1:0] gnt,
  output logic [ADDR_W-1:0] gnt_id,
  output logic              gnt_vld,
  output logic              proto_err,
  output logic              timeout
);
  logic [NUM_IN-1:0] req, err, req_m, kill;
  logic [NUM_IN-1:0] gnt_q, gnt_d, busy_n_q, busy_n_d;
  logic [ADDR_W-1:0] gnt_id_q, gnt_id_d, ptr_q, ptr_d, win_id;
  logic              gnt_vld_q, gnt_vld_d, proto_err_q;
  logic              win_found, release_w, force_rel, arb_go;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    router_oport_in_fsm #(.ADDR_W(ADDR_W), .PORT_ID(PORT_ID)) u_lane (
      .SystemClk (SystemClk),
      .reset_n   (reset_n),
      .frame_n_i (frame_n[i]),
      .valid_n_i (valid_n[i]),
      .din_i     (din[i]),
      .gnt_i     (gnt_q[i]),
      .kill_i    (kill[i]),
      .req_o     (req[i]),
      .err_o     (err[i])
    );
  end

  assign release_w = gnt_vld_q & frame_n[gnt_id_q] & ~valid_n[gnt_id_q];
  assign kill      = force_rel ? gnt_q : '0;
  assign req_m     = req & ~gnt_q;
  // Release and re-grant share one edge; a watchdog release leaves one idle cycle.
  assign arb_go    = (~gnt_vld_q | release_w) & ~force_rel & (|req_m);

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int off = 0; off < NUM_IN; off++) begin
      if (!win_found && req_m[(int'(ptr_q) + off) % NUM_IN]) begin
        win_found = 1'b1;
        win_id    = ADDR_W'((int'(ptr_q) + off) % NUM_IN);
      end
    end
  end

  always_comb begin
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
    if (release_w || force_rel) begin
      gnt_d     = '0;
      gnt_vld_d = 1'b0;
    end
    if (arb_go && win_found) begin
      gnt_d     = NUM_IN'(1) << win_id;
      gnt_id_d  = win_id;
      gnt_vld_d = 1'b1;
      ptr_d     = (win_id == ADDR_W'(NUM_IN - 1)) ? '0 : win_id + 1'b1;
    end
    busy_n_d = ~(req & ~gnt_d & ~kill);
  end

  always_ff @(posedge SystemClk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_vld_q   <= 1'b0;
      ptr_q       <= '0;
      busy_n_q    <= '1;
      proto_err_q <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_vld_q   <= gnt_vld_d;
      ptr_q       <= ptr_d;
      busy_n_q    <= busy_n_d;
      proto_err_q <= proto_err_q | (|err);
    end
  end

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q;
  logic          timeout_q;

  assign force_rel = gnt_vld_q & valid_n[gnt_id_q] & (wd_q == TW'(TIMEOUT - 1));

  always_ff @(posedge SystemClk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!gnt_vld_q || !valid_n[gnt_id_q] || force_rel) wd_q <= '0;
      else                                                wd_q <= wd_q + 1'b1;
      timeout_q <= timeout_q | force_rel;
    end
  end
  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign force_rel      = 1'b0;
  assign timeout        = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_vld   = gnt_vld_q;
  assign busy_n    = busy_n_q;
  assign proto_err = proto_err_q;
endmodule
